// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage in front of the 8-bit ALU: register file with writeback
// bypass, pending-destination scoreboard for RAW/WAW stalls, registered issue outputs.
module alu_issue_stage #(
  parameter int NREGS   = 8,
  parameter int DW      = 8,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [15:0]        in_instr,
  output logic               in_ready,
  input  logic               wb_en,
  input  logic [2:0]         wb_addr,
  input  logic [DW-1:0]      wb_data,
  output logic               issue_valid,
  output logic [DW-1:0]      alu_reg1,
  output logic [DW-1:0]      alu_reg2,
  output logic [3:0]         alu_func,
  output logic [2:0]         alu_spec_fun,
  output logic [2:0]         issue_rd,
  output logic               issue_we,
  output logic [STALL_W-1:0] stall_count
);

  logic [DW-1:0]    regfile [NREGS];
  logic [NREGS-1:0] pend;

  logic [3:0] func;
  logic [2:0] spec_fun, rd, rs1, rs2;
  logic       writer, we;
  logic       byp1, byp2, bypd;
  logic       hazard, accept;
  logic [DW-1:0] op1, op2;

  assign func     = in_instr[15:12];
  assign spec_fun = in_instr[11:9];
  assign rd       = in_instr[8:6];
  assign rs1      = in_instr[5:3];
  assign rs2      = in_instr[2:0];

  // add, sll, slr, spec write rd; everything else (branches included) does not
  assign writer = (func == 4'b0000) || (func == 4'b0011) ||
                  (func == 4'b0100) || (func == 4'b0111);
  assign we     = writer && (rd != 3'd0);

  assign byp1 = wb_en && (wb_addr == rs1);
  assign byp2 = wb_en && (wb_addr == rs2);
  assign bypd = wb_en && (wb_addr == rd);

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rs1 != 3'd0) op1 = byp1 ? wb_data : regfile[rs1];
    if (rs2 != 3'd0) op2 = byp2 ? wb_data : regfile[rs2];
  end

  // A writeback landing this cycle resolves the hazard it would otherwise cause
  assign hazard = ((rs1 != 3'd0) && pend[rs1] && !byp1) ||
                  ((rs2 != 3'd0) && pend[rs2] && !byp2) ||
                  (we && pend[rd] && !bypd);

  assign in_ready = !reset && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
      pend         <= '0;
      issue_valid  <= 1'b0;
      alu_reg1     <= '0;
      alu_reg2     <= '0;
      alu_func     <= '0;
      alu_spec_fun <= '0;
      issue_rd     <= '0;
      issue_we     <= 1'b0;
      stall_count  <= '0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        alu_reg1     <= op1;
        alu_reg2     <= op2;
        alu_func     <= func;
        alu_spec_fun <= spec_fun;
        issue_rd     <= rd;
        issue_we     <= we;
      end
      if (wb_en) begin
        if (wb_addr != 3'd0) regfile[wb_addr] <= wb_data;
        pend[wb_addr] <= 1'b0;
      end
      // Later assignment: a new claim on rd beats a same-edge writeback clear
      if (accept && we) pend[rd] <= 1'b1;
      if (in_valid && !in_ready && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed instructions, expected issue records queued at
// accept time and popped by an independent monitor whenever issue_valid is seen.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        issue_valid;
  logic [7:0]  alu_reg1, alu_reg2;
  logic [3:0]  alu_func;
  logic [2:0]  alu_spec_fun, issue_rd;
  logic        issue_we;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [3:0] func;
    logic [2:0] spec;
    logic [2:0] rd;
    logic       we;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_func(alu_func), .alu_spec_fun(alu_spec_fun), .issue_rd(issue_rd),
    .issue_we(issue_we), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] f, input logic [2:0] s,
                                      input logic [2:0] d, input logic [2:0] a,
                                      input logic [2:0] b);
    return {f, s, d, a, b};
  endfunction

  function automatic exp_t mk(input logic [7:0] r1, input logic [7:0] r2,
                              input logic [3:0] f, input logic [2:0] s,
                              input logic [2:0] d, input logic w);
    exp_t e;
    e = '{reg1: r1, reg2: r2, func: f, spec: s, rd: d, we: w};
    return e;
  endfunction

  // Monitor: every presented issue must match the oldest queued expectation
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clock);
      if (issue_valid) begin
        a = '{reg1: alu_reg1, reg2: alu_reg2, func: alu_func, spec: alu_spec_fun,
              rd: issue_rd, we: issue_we};
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {5'd0, a}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_record", {5'd0, a}, {5'd0, e});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [7:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    step();
    wb_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] instr, input exp_t e, input int max_wait);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clock);
    while (!in_ready && w < max_wait) begin
      @(negedge clock);
      w++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step();
    @(negedge clock);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("reset_stall", {16'd0, stall_count}, 32'd0);
    chk("reset_reg1", {24'd0, alu_reg1}, 32'd0);
    step();
    reset = 1'b0;

    // 1: basic add after writebacks
    wb(3'd1, 8'h05);
    wb(3'd2, 8'h03);
    send(ins(4'h0, 3'd0, 3'd3, 3'd1, 3'd2), mk(8'h05, 8'h03, 4'h0, 3'd0, 3'd3, 1'b1), 0);
    wb(3'd3, 8'h08);

    // 2: RAW stall until writeback; bypassed value on the release cycle
    send(ins(4'h0, 3'd0, 3'd1, 3'd2, 3'd2), mk(8'h03, 8'h03, 4'h0, 3'd0, 3'd1, 1'b1), 0);
    in_valid = 1'b1;
    in_instr = ins(4'h3, 3'd2, 3'd5, 3'd1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("raw_stall_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h22;
    @(negedge clock);
    chk("raw_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(mk(8'h22, 8'h08, 4'h3, 3'd2, 3'd5, 1'b1));
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("stall_after_raw", {16'd0, stall_count}, 32'd3);
    wb(3'd5, 8'h55);

    // 3: rs1=0 reads zero, rd=0 never writes
    send(ins(4'h4, 3'd7, 3'd0, 3'd0, 3'd1), mk(8'h00, 8'h22, 4'h4, 3'd7, 3'd0, 1'b0), 0);

    // 4: branch does not reserve rd; dependent reader issues back-to-back
    send(ins(4'hA, 3'd0, 3'd4, 3'd1, 3'd2), mk(8'h22, 8'h03, 4'hA, 3'd0, 3'd4, 1'b0), 0);
    send(ins(4'h7, 3'd1, 3'd6, 3'd4, 3'd0), mk(8'h00, 8'h00, 4'h7, 3'd1, 3'd6, 1'b1), 0);

    // 5: long stall on pending r6 saturates the counter; reset clears everything
    in_valid = 1'b1;
    in_instr = ins(4'h0, 3'd0, 3'd7, 3'd6, 3'd1);
    repeat (70000) @(posedge clock);
    @(negedge clock);
    chk("stall_saturated", {16'd0, stall_count}, 32'h0000_FFFF);
    chk("stall_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clock);
    chk("stall_holds", {16'd0, stall_count}, 32'h0000_FFFF);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("midreset_ready", {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clock);
    chk("midreset_stall", {16'd0, stall_count}, 32'd0);
    chk("midreset_reg1", {24'd0, alu_reg1}, 32'd0);
    step();
    reset = 1'b0;
    send(ins(4'h0, 3'd0, 3'd7, 3'd6, 3'd1), mk(8'h00, 8'h00, 4'h0, 3'd0, 3'd7, 1'b1), 0);
    wb(3'd1, 8'h11);
    send(ins(4'h3, 3'd0, 3'd3, 3'd1, 3'd0), mk(8'h11, 8'h00, 4'h3, 3'd0, 3'd3, 1'b1), 0);

    // 6: WAW stall, and a same-edge writeback clear losing to a new claim
    send(ins(4'h7, 3'd5, 3'd2, 3'd0, 3'd0), mk(8'h00, 8'h00, 4'h7, 3'd5, 3'd2, 1'b1), 0);
    in_valid = 1'b1;
    in_instr = ins(4'h0, 3'd0, 3'd2, 3'd0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("waw_stall_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h44;
    @(negedge clock);
    chk("waw_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 3'd0, 3'd2, 1'b1));
    step();
    wb_en = 1'b0;
    in_instr = ins(4'h0, 3'd0, 3'd2, 3'd2, 3'd0);
    @(negedge clock);
    chk("pend2_still_set", {31'd0, in_ready}, 32'd0);
    step();
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h66;
    @(negedge clock);
    chk("bypass_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(mk(8'h66, 8'h00, 4'h0, 3'd0, 3'd2, 1'b1));
    step();
    wb_en = 1'b0; in_valid = 1'b0;

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
